// File: rtl/btb_assoc_queued_if.sv
// Lookup/update bundle between fetch, branch resolution and btb_assoc_queued.
// The master side is the fetch/resolve logic; the slave side is the BTB.
interface btb_assoc_queued_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int RD_PORTS   = 2,
  parameter int WR_PORTS   = 2
) ();
  logic                                flush;
  logic [RD_PORTS-1:0]                 rd_valid;
  logic [RD_PORTS-1:0][ADDR_WIDTH-1:0] rd_pc;
  logic [RD_PORTS-1:0]                 rd_hit;
  logic [RD_PORTS-1:0][ADDR_WIDTH-1:0] rd_target;
  logic [WR_PORTS-1:0]                 upd_valid;
  logic [WR_PORTS-1:0][ADDR_WIDTH-1:0] upd_pc;
  logic [WR_PORTS-1:0][ADDR_WIDTH-1:0] upd_target;
  logic                                upd_ready;
  logic                                busy;

  modport master (
    output flush, rd_valid, rd_pc, upd_valid, upd_pc, upd_target,
    input  rd_hit, rd_target, upd_ready, busy
  );

  modport slave (
    input  flush, rd_valid, rd_pc, upd_valid, upd_pc, upd_target,
    output rd_hit, rd_target, upd_ready, busy
  );
endinterface

// File: rtl/btb_assoc_queued.sv
// Set-associative BTB with multi-port lookup and a queued, one-per-cycle update path.
// Optional macro BTB_UQ_BYPASS_EN: lookups also match pending update-queue entries.
module btb_assoc_queued #(
  parameter int ADDR_WIDTH = 32,
  parameter int SETS       = 256,
  parameter int WAYS       = 2,
  parameter int RD_PORTS   = 2,
  parameter int WR_PORTS   = 2,
  parameter int UQ_DEPTH   = 4
) (
  input logic              clk,
  input logic              reset,
  btb_assoc_queued_if.slave bus
);
  localparam int IDX    = $clog2(SETS);
  localparam int TAG_W  = ADDR_WIDTH - IDX - 2;
  localparam int WAY_W  = $clog2(WAYS);
  localparam int QP_W   = (UQ_DEPTH > 1) ? $clog2(UQ_DEPTH) : 1;
  localparam int CNT_W  = $clog2(UQ_DEPTH + 1);
  localparam int SUM_W  = CNT_W + 1;
  localparam int LINE_W = ADDR_WIDTH - 2;

  typedef enum logic {INIT, READY} state_t;

  state_t                              state_reg;
  logic [IDX-1:0]                      sweep_reg;
  logic [QP_W-1:0]                     head_reg;
  logic [QP_W-1:0]                     tail_reg;
  logic [CNT_W-1:0]                    count_reg;
  logic [RD_PORTS-1:0]                 rd_hit_reg;
  logic [RD_PORTS-1:0][ADDR_WIDTH-1:0] rd_target_reg;

  logic [WAYS-1:0]       valid_mem  [SETS];
  logic [WAY_W-1:0]      victim_mem [SETS];
  logic [LINE_W-1:0]     q_pc       [UQ_DEPTH];
  logic [ADDR_WIDTH-1:0] q_tgt      [UQ_DEPTH];

  function automatic logic [QP_W-1:0] ptr_add(input logic [QP_W-1:0] ptr,
                                               input logic [CNT_W-1:0] k);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(ptr) + SUM_W'(k);
    if (sum >= SUM_W'(UQ_DEPTH))
      sum = sum - SUM_W'(UQ_DEPTH);
    return QP_W'(sum);
  endfunction

  logic             ready_state;
  logic             upd_fire;
  logic             drain_en;
  logic [CNT_W-1:0] free_slots;
  logic [CNT_W-1:0] enq_cnt;
  logic [QP_W-1:0]  enq_pos [WR_PORTS];

  assign ready_state = (state_reg == READY);
  assign free_slots  = CNT_W'(UQ_DEPTH) - count_reg;
  assign upd_fire    = ready_state && (free_slots >= CNT_W'(WR_PORTS));
  // A flush or reset on this edge discards the entry that would have retired.
  assign drain_en    = ready_state && (count_reg != '0) && !reset && !bus.flush;

  // Valid update ports are packed into consecutive slots, port 0 first.
  always_comb begin
    enq_cnt = '0;
    for (int j = 0; j < WR_PORTS; j++) begin
      enq_pos[j] = ptr_add(tail_reg, enq_cnt);
      if (upd_fire && bus.upd_valid[j])
        enq_cnt = enq_cnt + CNT_W'(1);
    end
  end

  logic [LINE_W-1:0]           drain_line;
  logic [IDX-1:0]              drain_set;
  logic [TAG_W-1:0]            drain_tag;
  logic [ADDR_WIDTH-1:0]       drain_tgt;
  logic [WAYS-1:0]             drain_valid;
  logic [WAYS-1:0]             drain_match;
  logic [WAYS-1:0][TAG_W-1:0]  drain_tag_rd;
  logic [WAY_W-1:0]            drain_way;
  logic                        drain_evict;

  assign drain_line  = q_pc[head_reg];
  assign drain_set   = drain_line[IDX-1:0];
  assign drain_tag   = drain_line[LINE_W-1:IDX];
  assign drain_tgt   = q_tgt[head_reg];
  assign drain_valid = valid_mem[drain_set];

  logic [IDX-1:0]                    look_set [RD_PORTS];
  logic [TAG_W-1:0]                  look_tag [RD_PORTS];
  logic [RD_PORTS-1:0][WAYS-1:0]     look_match;
  logic [ADDR_WIDTH-1:0]             look_tgt [RD_PORTS][WAYS];

  genvar gi, gj;
  generate
    for (gi = 0; gi < RD_PORTS; gi++) begin : g_port
      assign look_set[gi] = bus.rd_pc[gi][IDX+1:2];
      assign look_tag[gi] = bus.rd_pc[gi][ADDR_WIDTH-1:IDX+2];
    end

    for (gi = 0; gi < WAYS; gi++) begin : g_way
      logic [TAG_W-1:0]      tag_mem [SETS];
      logic [ADDR_WIDTH-1:0] tgt_mem [SETS];

      always_ff @(posedge clk) begin
        if (drain_en && drain_way == WAY_W'(gi)) begin
          tag_mem[drain_set] <= drain_tag;
          tgt_mem[drain_set] <= drain_tgt;
        end
      end

      assign drain_tag_rd[gi] = tag_mem[drain_set];
      assign drain_match[gi]  = drain_valid[gi] && (drain_tag_rd[gi] == drain_tag);

      for (gj = 0; gj < RD_PORTS; gj++) begin : g_look
        assign look_match[gj][gi] = valid_mem[look_set[gj]][gi] &&
                                    (tag_mem[look_set[gj]] == look_tag[gj]);
        assign look_tgt[gj][gi]   = tgt_mem[look_set[gj]];
      end
    end
  endgenerate

  // Retiring way: existing tag, else lowest free way, else the round-robin victim.
  always_comb begin
    logic found;
    found       = 1'b0;
    drain_way   = victim_mem[drain_set];
    for (int w = 0; w < WAYS; w++) begin
      if (!found && drain_match[w]) begin
        drain_way = WAY_W'(w);
        found     = 1'b1;
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !drain_valid[w]) begin
        drain_way = WAY_W'(w);
        found     = 1'b1;
      end
    end
    drain_evict = !found;
  end

  logic [RD_PORTS-1:0]                 look_hit;
  logic [RD_PORTS-1:0][ADDR_WIDTH-1:0] look_target;

  always_comb begin
    look_hit    = '0;
    look_target = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      // Descending scan so the lowest matching way is the one kept.
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (look_match[p][w]) begin
          look_hit[p]    = 1'b1;
          look_target[p] = look_tgt[p][w];
        end
      end
`ifdef BTB_UQ_BYPASS_EN
      // Oldest to youngest so the youngest queue match overrides.
      for (int k = 0; k < UQ_DEPTH; k++) begin
        if (CNT_W'(k) < count_reg &&
            q_pc[ptr_add(head_reg, CNT_W'(k))] == bus.rd_pc[p][ADDR_WIDTH-1:2]) begin
          look_hit[p]    = 1'b1;
          look_target[p] = q_tgt[ptr_add(head_reg, CNT_W'(k))];
        end
      end
      for (int j = 0; j < WR_PORTS; j++) begin
        if (upd_fire && bus.upd_valid[j] &&
            bus.upd_pc[j][ADDR_WIDTH-1:2] == bus.rd_pc[p][ADDR_WIDTH-1:2]) begin
          look_hit[p]    = 1'b1;
          look_target[p] = bus.upd_target[j];
        end
      end
`endif
      if (!bus.rd_valid[p]) begin
        look_hit[p]    = 1'b0;
        look_target[p] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      state_reg     <= INIT;
      sweep_reg     <= '0;
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      rd_hit_reg    <= '0;
      rd_target_reg <= '0;
    end else if (state_reg == INIT) begin
      valid_mem[sweep_reg]  <= '0;
      victim_mem[sweep_reg] <= '0;
      sweep_reg             <= sweep_reg + IDX'(1);
      if (sweep_reg == IDX'(SETS - 1))
        state_reg <= READY;
      rd_hit_reg    <= '0;
      rd_target_reg <= '0;
    end else begin
      rd_hit_reg    <= look_hit;
      rd_target_reg <= look_target;
      tail_reg      <= ptr_add(tail_reg, enq_cnt);
      count_reg     <= count_reg + enq_cnt - CNT_W'(drain_en);
      if (drain_en) begin
        head_reg                        <= ptr_add(head_reg, CNT_W'(1));
        valid_mem[drain_set][drain_way] <= 1'b1;
        if (drain_evict)
          victim_mem[drain_set] <= drain_way + WAY_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < WR_PORTS; j++) begin
      if (upd_fire && bus.upd_valid[j]) begin
        q_pc[enq_pos[j]]  <= bus.upd_pc[j][ADDR_WIDTH-1:2];
        q_tgt[enq_pos[j]] <= bus.upd_target[j];
      end
    end
  end

  // Byte-offset bits of the PCs carry no information for a word-aligned BTB.
  logic unused_lsbs;
  always_comb begin
    unused_lsbs = 1'b0;
    for (int p = 0; p < RD_PORTS; p++)
      unused_lsbs = unused_lsbs ^ (^bus.rd_pc[p][1:0]);
    for (int j = 0; j < WR_PORTS; j++)
      unused_lsbs = unused_lsbs ^ (^bus.upd_pc[j][1:0]);
  end

  assign bus.rd_hit    = rd_hit_reg;
  assign bus.rd_target = rd_target_reg;
  assign bus.upd_ready = upd_fire;
  assign bus.busy      = (state_reg == INIT);
endmodule

// File: tb/tb_btb_assoc_queued.sv
// Directed self-checking bench for btb_assoc_queued (default geometry 256x2, 2R/2W, queue 4).
// Expected values are hand-derived; the bypass expectation follows BTB_UQ_BYPASS_EN.
module tb_btb_assoc_queued;
  localparam int AW = 32;
`ifdef BTB_UQ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  btb_assoc_queued_if #(.ADDR_WIDTH(AW), .RD_PORTS(2), .WR_PORTS(2)) bus ();

  btb_assoc_queued #(
    .ADDR_WIDTH(AW), .SETS(256), .WAYS(2), .RD_PORTS(2), .WR_PORTS(2), .UQ_DEPTH(4)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_lookup(input logic [AW-1:0] p0, input logic [AW-1:0] p1,
                           output logic h0, output logic [AW-1:0] t0,
                           output logic h1, output logic [AW-1:0] t1);
    bus.rd_valid = 2'b11;
    bus.rd_pc[0] = p0;
    bus.rd_pc[1] = p1;
    @(negedge clk);
    h0 = bus.rd_hit[0];
    t0 = bus.rd_target[0];
    h1 = bus.rd_hit[1];
    t1 = bus.rd_target[1];
    bus.rd_valid = 2'b00;
    $display("lookup pc0=%h hit=%0b tgt=%h | pc1=%h hit=%0b tgt=%h", p0, h0, t0, p1, h1, t1);
  endtask

  task automatic do_update(input logic [AW-1:0] p0, input logic [AW-1:0] g0, input logic v0,
                           input logic [AW-1:0] p1, input logic [AW-1:0] g1, input logic v1);
    bus.upd_valid     = {v1, v0};
    bus.upd_pc[0]     = p0;
    bus.upd_target[0] = g0;
    bus.upd_pc[1]     = p1;
    bus.upd_target[1] = g1;
    $display("update v=%b pc0=%h->%h pc1=%h->%h ready=%0b", {v1, v0}, p0, g0, p1, g1, bus.upd_ready);
    @(negedge clk);
    bus.upd_valid = 2'b00;
  endtask

  task automatic wait_init(input int start, output int cnt);
    cnt = start;
    while (bus.busy === 1'b1 && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic h0, h1;
    logic [AW-1:0] t0, t1;
    int cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.upd_ready !== 1'b0 || bus.rd_hit !== 2'b00 || bus.rd_target !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b ready=%b hit=%b tgt=%h, expected busy=1 ready=0 hit=00 tgt=0",
               bus.busy, bus.upd_ready, bus.rd_hit, bus.rd_target);
    end
    do_update(32'h7000, 32'h70, 1'b1, 32'h0, 32'h0, 1'b0);
    wait_init(1, cnt);
    checks++;
    if (cnt !== 256) begin
      errors++;
      $display("FAIL init_length: busy cycles=%0d, expected 256", cnt);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.upd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_init: busy=%b ready=%b, expected busy=0 ready=1", bus.busy, bus.upd_ready);
    end
    do_lookup(32'h1000, 32'h7000, h0, t0, h1, t1);
    checks++;
    if (h0 !== 1'b0 || t0 !== 32'h0) begin
      errors++;
      $display("FAIL cold_miss: hit=%b tgt=%h, expected hit=0 tgt=0", h0, t0);
    end
    checks++;
    if (h1 !== 1'b0 || t1 !== 32'h0) begin
      errors++;
      $display("FAIL dropped_update: hit=%b tgt=%h, expected hit=0 tgt=0", h1, t1);
    end
  endtask

  task automatic test_basic();
    logic h0, h1;
    logic [AW-1:0] t0, t1;
    do_update(32'h1000, 32'h2000, 1'b1, 32'h0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    do_lookup(32'h1000, 32'h5000, h0, t0, h1, t1);
    checks++;
    if (h0 !== 1'b1 || t0 !== 32'h2000) begin
      errors++;
      $display("FAIL basic_hit: hit=%b tgt=%h, expected hit=1 tgt=00002000", h0, t0);
    end
    checks++;
    if (h1 !== 1'b0 || t1 !== 32'h0) begin
      errors++;
      $display("FAIL basic_tag_miss: hit=%b tgt=%h, expected hit=0 tgt=0", h1, t1);
    end
    bus.rd_valid = 2'b00;
    bus.rd_pc[0] = 32'h1000;
    bus.rd_pc[1] = 32'h1000;
    @(negedge clk);
    checks++;
    if (bus.rd_hit !== 2'b00 || bus.rd_target !== '0) begin
      errors++;
      $display("FAIL idle_no_hit: hit=%b tgt=%h, expected hit=00 tgt=0", bus.rd_hit, bus.rd_target);
    end
  endtask

  task automatic test_evict();
    logic h0, h1;
    logic [AW-1:0] t0, t1;
    do_update(32'h1000, 32'hA0, 1'b1, 32'h0, 32'h0, 1'b0);
    do_update(32'h5000, 32'hB0, 1'b1, 32'h0, 32'h0, 1'b0);
    do_update(32'h9000, 32'hC0, 1'b1, 32'h0, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    do_lookup(32'h1000, 32'h5000, h0, t0, h1, t1);
    checks++;
    if (h0 !== 1'b0 || t0 !== 32'h0) begin
      errors++;
      $display("FAIL evicted_way0: hit=%b tgt=%h, expected hit=0 tgt=0", h0, t0);
    end
    checks++;
    if (h1 !== 1'b1 || t1 !== 32'hB0) begin
      errors++;
      $display("FAIL kept_way1: hit=%b tgt=%h, expected hit=1 tgt=000000b0", h1, t1);
    end
    do_lookup(32'h9000, 32'h9000, h0, t0, h1, t1);
    checks++;
    if (h0 !== 1'b1 || t0 !== 32'hC0 || h1 !== 1'b1 || t1 !== 32'hC0) begin
      errors++;
      $display("FAIL same_pc_ports: hit=%b/%b tgt=%h/%h, expected hit=1/1 tgt=c0/c0", h0, h1, t0, t1);
    end
    // Victim pointer has advanced to way 1, so 0xD000 must replace 0x5000.
    do_update(32'hD000, 32'hD0, 1'b1, 32'h0, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    do_lookup(32'h5000, 32'hD000, h0, t0, h1, t1);
    checks++;
    if (h0 !== 1'b0 || t0 !== 32'h0) begin
      errors++;
      $display("FAIL victim_advance: hit=%b tgt=%h, expected hit=0 tgt=0", h0, t0);
    end
    checks++;
    if (h1 !== 1'b1 || t1 !== 32'hD0) begin
      errors++;
      $display("FAIL victim_fill: hit=%b tgt=%h, expected hit=1 tgt=000000d0", h1, t1);
    end
  endtask

  task automatic test_back_to_back();
    logic h0, h1;
    logic [AW-1:0] t0, t1;
    logic [3:0] exp_ready;
    logic [AW-1:0] pa, pb;
    exp_ready = 4'b1011;  // bit k = upd_ready seen in offer cycle k
    for (int k = 0; k < 4; k++) begin
      pa = 32'h2000 + 32'((k * 2 + 1) * 4);
      pb = 32'h2000 + 32'((k * 2 + 2) * 4);
      checks++;
      if (bus.upd_ready !== exp_ready[k]) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: ready=%b, expected %b", k, bus.upd_ready, exp_ready[k]);
      end
      do_update(pa, 32'h4000 + 32'(k * 16), 1'b1, pb, 32'h4001 + 32'(k * 16), 1'b1);
    end
    repeat (5) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      pa = 32'h2000 + 32'((k * 2 + 1) * 4);
      pb = 32'h2000 + 32'((k * 2 + 2) * 4);
      do_lookup(pa, pb, h0, t0, h1, t1);
      checks++;
      if (k == 2) begin
        if (h0 !== 1'b0 || h1 !== 1'b0 || t0 !== 32'h0 || t1 !== 32'h0) begin
          errors++;
          $display("FAIL b2b_dropped[%0d]: hit=%b/%b tgt=%h/%h, expected misses", k, h0, h1, t0, t1);
        end
      end else begin
        if (h0 !== 1'b1 || h1 !== 1'b1 || t0 !== 32'h4000 + 32'(k * 16) || t1 !== 32'h4001 + 32'(k * 16)) begin
          errors++;
          $display("FAIL b2b_accepted[%0d]: hit=%b/%b tgt=%h/%h, expected hit=1/1 tgt=%h/%h",
                   k, h0, h1, t0, t1, 32'h4000 + 32'(k * 16), 32'h4001 + 32'(k * 16));
        end
      end
    end
  endtask

  task automatic test_duplicate();
    logic h0, h1;
    logic [AW-1:0] t0, t1;
    do_update(32'h3000, 32'h10, 1'b1, 32'h3000, 32'h20, 1'b1);
    do_lookup(32'h3000, 32'h3000, h0, t0, h1, t1);
    checks++;
    if (h0 !== BYPASS || t0 !== (BYPASS ? 32'h20 : 32'h0)) begin
      errors++;
      $display("FAIL dup_early_lookup: hit=%b tgt=%h, expected hit=%b tgt=%h",
               h0, t0, BYPASS, BYPASS ? 32'h20 : 32'h0);
    end
    repeat (3) @(negedge clk);
    do_lookup(32'h3000, 32'hD000, h0, t0, h1, t1);
    checks++;
    if (h0 !== 1'b1 || t0 !== 32'h20) begin
      errors++;
      $display("FAIL dup_youngest: hit=%b tgt=%h, expected hit=1 tgt=00000020", h0, t0);
    end
    checks++;
    if (h1 !== 1'b1 || t1 !== 32'hD0) begin
      errors++;
      $display("FAIL dup_other_way: hit=%b tgt=%h, expected hit=1 tgt=000000d0", h1, t1);
    end
    do_lookup(32'h9000, 32'h1000, h0, t0, h1, t1);
    checks++;
    if (h0 !== 1'b0 || h1 !== 1'b0) begin
      errors++;
      $display("FAIL dup_evicted: hit=%b/%b, expected 0/0", h0, h1);
    end
  endtask

  task automatic test_abort(input bit use_reset, input string name);
    logic h0, h1;
    logic [AW-1:0] t0, t1;
    logic [AW-1:0] pcs [6];
    int cnt, start;
    pcs = '{32'h6004, 32'h6008, 32'h600C, 32'h6010, 32'h3000, 32'hD000};
    do_update(32'h6004, 32'h61, 1'b1, 32'h6008, 32'h62, 1'b1);
    do_update(32'h600C, 32'h63, 1'b1, 32'h6010, 32'h64, 1'b1);
    if (use_reset) rst = 1'b1;
    else bus.flush = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.upd_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_state: busy=%b ready=%b, expected busy=1 ready=0", name, bus.busy, bus.upd_ready);
    end
    do_lookup(32'h6004, 32'hD000, h0, t0, h1, t1);
    checks++;
    if (h0 !== 1'b0 || h1 !== 1'b0) begin
      errors++;
      $display("FAIL %s_init_lookup: hit=%b/%b, expected 0/0", name, h0, h1);
    end
    start = 1;
    if (!use_reset) begin
      repeat (10) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      start = 0;
    end
    wait_init(start, cnt);
    checks++;
    if (cnt !== 256) begin
      errors++;
      $display("FAIL %s_init_length: busy cycles=%0d, expected 256", name, cnt);
    end
    checks++;
    if (bus.upd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_queue_empty: ready=%b, expected 1", name, bus.upd_ready);
    end
    for (int i = 0; i < 6; i += 2) begin
      do_lookup(pcs[i], pcs[i+1], h0, t0, h1, t1);
      checks++;
      if (h0 !== 1'b0 || h1 !== 1'b0 || t0 !== 32'h0 || t1 !== 32'h0) begin
        errors++;
        $display("FAIL %s_all_miss: pc=%h/%h hit=%b/%b tgt=%h/%h, expected misses",
                 name, pcs[i], pcs[i+1], h0, h1, t0, t1);
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.flush      = 1'b0;
    bus.rd_valid   = '0;
    bus.rd_pc      = '0;
    bus.upd_valid  = '0;
    bus.upd_pc     = '0;
    bus.upd_target = '0;
    test_reset();
    test_basic();
    test_evict();
    test_back_to_back();
    test_duplicate();
    test_abort(1'b0, "flush");
    test_abort(1'b1, "reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
